if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage and IF/ID pipeline register for the 64-bit MIPS CPU. Keeps the PC and issues single-outstanding requests to instruction memory. Buffers returned words into IF/ID and drives the 6-bit opcode consumed by `control_unit`. Redirects on taken branches (from EX) and jumps (from ID), dropping stale in-flight fetches.

## Interface
- PC_W, 64, PC / address width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  PC_W  fetch address; meaningful only while imem_req=1
- imem_valid  in  1  one response per request, in order, ≥1 cycle after its request
- imem_rdata  in  32  instruction word, valid with imem_valid
- stall  in  1  hazard unit: hold IF/ID contents
- branch_taken  in  1  EX-stage taken branch
- branch_target  in  PC_W  target for branch_taken
- jump  in  1  ID-stage jump (from control_unit Jump)
- jump_target  in  PC_W  target for jump
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_inst  out  32  IF/ID instruction; forced to 32'h0 when invalid
- if_id_pc4  out  PC_W  address of that instruction + 4
- opcode  out  6  if_id_inst[31:26], to control_unit

## Operation
- Registers: pc (next fetch address), req_pc (address of outstanding fetch), state ∈ {IDLE, WAIT, DISCARD}, boot_done, hold buffer (valid, inst, pc4), IF/ID (valid, inst, pc4).
- redirect = branch_taken | (jump & ~stall). jump is ignored while stall=1. branch_taken overrides stall and wins over jump.
- On redirect: pc ← branch_target if branch_taken, else jump_target. IF/ID valid←0 and inst←0. Hold buffer cleared. No request issued that cycle.
- Issue (imem_req=1, imem_addr=pc, req_pc←pc, pc←pc+4, state→WAIT) when boot_done & ~redirect & ~hold.valid and either:
  - state=IDLE, or
  - state=WAIT & imem_valid, with the response going to IF/ID rather than hold.
- WAIT, imem_valid, no redirect: response is delivered.
  - If ~if_id_valid or ~stall, and hold empty: IF/ID ← {1, imem_rdata, req_pc+4}.
  - Else: hold ← response.
  - State→IDLE unless a back-to-back issue occurs.
- WAIT, redirect: if imem_valid in the same cycle, drop the response and go to IDLE; otherwise go to DISCARD.
- DISCARD: the next imem_valid is dropped, state→IDLE. A redirect in DISCARD only updates pc.
- IF/ID advance when ~stall or ~if_id_valid, with no redirect. Source priority: hold buffer (older), then delivered response, else bubble (valid 0, inst 0).
- imem_valid in IDLE is a protocol error and is ignored.
- pc arithmetic: modulo 2^PC_W; wraps silently.

## Timing
- Reset (async, rst_n low) values:
  - pc=RESET_PC, state=IDLE, boot_done=0.
  - hold and IF/ID invalid, inst 0, pc4 0.
  - imem_req=0, imem_addr=0, opcode=0.
- boot_done sets on the first rising edge with rst_n high. The first imem_req is in the second cycle after reset release.
- imem_req and imem_addr are combinational from registered state plus current inputs.
- Latency, 1-cycle memory: request in cycle t, imem_valid in t+1, if_id_valid in t+2.
- Throughput: 1 instruction/cycle with 1-cycle memory and no stall.
- Redirect asserted in cycle t: IF/ID is a bubble in t+1; the first request to the target is in t+1 if state is IDLE.
- Reset mid-operation: immediate return to reset values. Any later imem_valid for a pre-reset request arrives while IDLE and is ignored.

## Test plan
- Reset release, RESET_PC=0x100, 1-cycle memory returning 0x8C080004 -> imem_req in cycle 2 with addr 0x100. Cycle 4: if_id_valid=1, inst=0x8C080004, opcode=6'b100011, pc4=0x104.
- Streaming, 1-cycle memory, 4 words -> addresses 0x100..0x10C on consecutive cycles. IF/ID shows each word on consecutive cycles, pc4 stepping by 4.
- stall=1 for 3 cycles with a response arriving while IF/ID is valid -> IF/ID unchanged, hold fills, imem_req stays low. After stall drops: hold word in IF/ID next cycle, then a new issue.
- branch_taken=1, target 0x200, while a 3-cycle-latency fetch is outstanding -> state DISCARD, stale word never reaches IF/ID, next request addr=0x200, IF/ID bubble (inst 0).
- jump=1 with stall=1 -> ignored, pc unchanged. jump=1 with stall=0 and branch_taken=1 in the same cycle -> branch_target used.
- rst_n pulsed low while in WAIT -> all outputs at reset values immediately. Late imem_valid is ignored. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
interface if_stage_if #(
  parameter int PC_W = 64
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID register: single outstanding fetch, one-entry hold
// buffer for responses that land during a stall, redirect with stale-response discard.
module if_stage #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  if_stage_if.master      imem,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic            if_id_valid,
  output logic [31:0]     if_id_inst,
  output logic [PC_W-1:0] if_id_pc4,
  output logic [5:0]      opcode
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            boot_done_q;
  logic            hold_valid_q, hold_valid_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic [PC_W-1:0] hold_pc4_q, hold_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;
  logic [PC_W-1:0] ifid_pc4_q, ifid_pc4_d;

  logic            redirect_s;
  logic [PC_W-1:0] redirect_pc_s;
  logic            advance_s;
  logic            deliver_s;
  logic            to_ifid_s;
  logic            issue_s;
  logic [PC_W-1:0] resp_pc4_s;

  // Next-state, redirect, issue and IF/ID/hold steering
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;

    // Branch from EX beats both stall and an ID-stage jump
    redirect_s    = branch_taken | (jump & ~stall);
    redirect_pc_s = branch_taken ? branch_target : jump_target;
    advance_s     = (~stall | ~ifid_valid_q) & ~redirect_s;
    deliver_s     = (state_q == WAIT) & imem.imem_valid & ~redirect_s;
    to_ifid_s     = deliver_s & advance_s & ~hold_valid_q;
    resp_pc4_s    = req_pc_q + PC_W'(4);
    issue_s       = boot_done_q & ~redirect_s & ~hold_valid_q &
                    ((state_q == IDLE) | to_ifid_s);

    imem.imem_req  = issue_s;
    imem.imem_addr = issue_s ? pc_q : {PC_W{1'b0}};

    case (state_q)
      IDLE: begin
        if (issue_s) state_d = WAIT;
        else         state_d = IDLE;
      end
      WAIT: begin
        if (redirect_s)           state_d = imem.imem_valid ? IDLE : DISCARD;
        else if (imem.imem_valid) state_d = issue_s ? WAIT : IDLE;
        else                      state_d = WAIT;
      end
      DISCARD: begin
        if (imem.imem_valid) state_d = IDLE;
        else                 state_d = DISCARD;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_s) begin
      pc_d = redirect_pc_s;
    end else if (issue_s) begin
      pc_d     = pc_q + PC_W'(4);
      req_pc_d = pc_q;
    end else begin
      pc_d = pc_q;
    end

    if (redirect_s) begin
      ifid_valid_d = 1'b0;
      ifid_inst_d  = 32'h0;
      hold_valid_d = 1'b0;
      hold_inst_d  = 32'h0;
    end else begin
      // The hold buffer is older than anything arriving now, so it drains first
      if (advance_s) begin
        if (hold_valid_q) begin
          ifid_valid_d = 1'b1;
          ifid_inst_d  = hold_inst_q;
          ifid_pc4_d   = hold_pc4_q;
          hold_valid_d = 1'b0;
          hold_inst_d  = 32'h0;
        end else if (to_ifid_s) begin
          ifid_valid_d = 1'b1;
          ifid_inst_d  = imem.imem_rdata;
          ifid_pc4_d   = resp_pc4_s;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_inst_d  = 32'h0;
        end
      end else begin
        ifid_valid_d = ifid_valid_q;
      end
      if (deliver_s & ~to_ifid_s) begin
        hold_valid_d = 1'b1;
        hold_inst_d  = imem.imem_rdata;
        hold_pc4_d   = resp_pc4_s;
      end else begin
        hold_pc4_d = hold_pc4_d;
      end
    end
  end

  // State, PC, hold buffer and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= {PC_W{1'b0}};
      boot_done_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= 32'h0;
      hold_pc4_q   <= {PC_W{1'b0}};
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= 32'h0;
      ifid_pc4_q   <= {PC_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      boot_done_q  <= 1'b1;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign if_id_valid = ifid_valid_q;
  assign if_id_inst  = ifid_inst_q;
  assign if_id_pc4   = ifid_pc4_q;
  assign opcode      = ifid_inst_q[31:26];

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a latency-programmable instruction memory, an
// expected-fetch-address model and a queue of expected IF/ID contents.
module tb_if_stage;

  localparam logic [63:0] RESET_PC = 64'h100;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc4;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        jump = 1'b0;
  logic [63:0] jump_target = 64'h0;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [63:0] if_id_pc4;
  logic [5:0]  opcode;

  if_stage_if #(.PC_W(64)) bus ();

  if_stage #(.PC_W(64), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .if_id_valid   (if_id_valid),
    .if_id_inst    (if_id_inst),
    .if_id_pc4     (if_id_pc4),
    .opcode        (opcode)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] cyc = 32'd0;
  logic [31:0] last_due = 32'd0;
  logic [31:0] mem_lat = 32'd1;
  logic [63:0] exp_pc = RESET_PC;
  logic        adv_prev = 1'b1;
  logic        bubble_exp = 1'b0;
  logic        redir = 1'b0;
  exp_t        cur = '0;
  exp_t        e;
  mreq_t       m;
  bit          ok;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h100) return 32'h8C08_0004;
    return {a[31:2], 2'b00} ^ 32'h2400_0000;
  endfunction

  task automatic wait_req(input string tag, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = bus.imem_req;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  // Instruction memory: in-order responses, each at least mem_lat cycles after its request
  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      cyc = cyc + 32'd1;
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
      end
    end
  end

  // Monitor: checks IF/ID against the scoreboard and request addresses against the PC model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_pc     = RESET_PC;
        adv_prev   = 1'b1;
        bubble_exp = 1'b0;
      end else begin
        redir = branch_taken | (jump & ~stall);
        if (bubble_exp) begin
          check("redir_bubble_valid", 64'(if_id_valid), 64'd0);
          check("redir_bubble_inst", 64'(if_id_inst), 64'd0);
        end else if (if_id_valid) begin
          if (adv_prev) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
            else cur = exp_q.pop_front();
          end
          check("ifid_inst", 64'(if_id_inst), 64'(cur.inst));
          check("ifid_pc4", if_id_pc4, cur.pc4);
          check("ifid_opcode", 64'(opcode), 64'(cur.inst[31:26]));
        end else begin
          check("bubble_inst", 64'(if_id_inst), 64'd0);
        end
        if (bus.imem_req) begin
          check("req_addr", bus.imem_addr, exp_pc);
          e.inst = mem_word(exp_pc);
          e.pc4  = exp_pc + 64'd4;
          exp_q.push_back(e);
          exp_pc = exp_pc + 64'd4;
          m.addr = bus.imem_addr;
          m.due  = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due + 32'd1;
          last_due = m.due;
          mem_q.push_back(m);
        end
        if (redir) begin
          check("redir_noreq", 64'(bus.imem_req), 64'd0);
          exp_q.delete();
          exp_pc = branch_taken ? branch_target : jump_target;
        end
        bubble_exp = redir;
        adv_prev   = (~stall | ~if_id_valid) & ~redir;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_addr", bus.imem_addr, 64'd0);
    check("rst_valid", 64'(if_id_valid), 64'd0);
    check("rst_inst", 64'(if_id_inst), 64'd0);
    check("rst_pc4", if_id_pc4, 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    rst_n = 1'b1;

    // Boot latency: request in cycle 2, IF/ID valid in cycle 4
    @(negedge clk); check("boot_c1_req", 64'(bus.imem_req), 64'd0);
    @(negedge clk); check("boot_c2_req", 64'(bus.imem_req), 64'd1);
    check("boot_c2_addr", bus.imem_addr, 64'h100);
    @(negedge clk); check("boot_c3_valid", 64'(if_id_valid), 64'd0);
    @(negedge clk);
    check("boot_c4_valid", 64'(if_id_valid), 64'd1);
    check("boot_c4_inst", 64'(if_id_inst), 64'h8C08_0004);
    check("boot_c4_opcode", 64'(opcode), 64'(6'b100011));
    check("boot_c4_pc4", if_id_pc4, 64'h104);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("stream_valid", 64'(if_id_valid), 64'd1);
      check("stream_pc4", if_id_pc4, 64'h104 + 64'(4 * i));
    end

    // Stall for three cycles while a response lands: it must go to the hold buffer
    @(posedge clk); #1; stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_noreq", 64'(bus.imem_req), 64'd0);
      check("stall_valid", 64'(if_id_valid), 64'd1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall_noreq", 64'(bus.imem_req), 64'd0);
    check("unstall_valid", 64'(if_id_valid), 64'd1);
    @(negedge clk); check("unstall_issue", 64'(bus.imem_req), 64'd1);

    // Taken branch with a 3-cycle fetch in flight: stale word dropped via DISCARD
    @(posedge clk); #1; mem_lat = 32'd3;
    wait_req("br_outstanding", ok);
    @(posedge clk); #1; branch_taken = 1'b1; branch_target = 64'h200;
    @(negedge clk);
    @(posedge clk); #1; branch_taken = 1'b0; branch_target = 64'h0;
    @(negedge clk);
    check("disc_noreq1", 64'(bus.imem_req), 64'd0);
    check("disc_bubble", 64'(if_id_inst), 64'd0);
    @(negedge clk); check("disc_noreq2", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    check("br_req", 64'(bus.imem_req), 64'd1);
    check("br_addr", bus.imem_addr, 64'h200);

    // Jump under stall is ignored
    @(posedge clk); #1; mem_lat = 32'd1;
    repeat (8) @(posedge clk);
    #1; stall = 1'b1; jump = 1'b1; jump_target = 64'h300;
    @(posedge clk); #1; stall = 1'b0; jump = 1'b0; jump_target = 64'h0;
    wait_req("jstall_req", ok);
    check("jstall_not_target", 64'(bus.imem_addr == 64'h300), 64'd0);

    // Branch and jump together: branch target wins
    @(posedge clk); #1;
    jump = 1'b1; jump_target = 64'h500; branch_taken = 1'b1; branch_target = 64'h400;
    @(posedge clk); #1;
    jump = 1'b0; jump_target = 64'h0; branch_taken = 1'b0; branch_target = 64'h0;
    wait_req("bj_req", ok);
    check("bj_addr", bus.imem_addr, 64'h400);

    // PC wraps modulo 2^64
    @(posedge clk); #1; branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFF8;
    @(posedge clk); #1; branch_taken = 1'b0; branch_target = 64'h0;
    wait_req("wrap_req0", ok); check("wrap_addr0", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    wait_req("wrap_req1", ok); check("wrap_addr1", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("wrap_req2", ok); check("wrap_addr2", bus.imem_addr, 64'h0);

    // Reset while a fetch is outstanding; its late response must be ignored
    @(posedge clk); #1; mem_lat = 32'd3;
    wait_req("mrst_outstanding", ok);
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    check("mrst_req", 64'(bus.imem_req), 64'd0);
    check("mrst_addr", bus.imem_addr, 64'd0);
    check("mrst_valid", 64'(if_id_valid), 64'd0);
    check("mrst_inst", 64'(if_id_inst), 64'd0);
    check("mrst_pc4", if_id_pc4, 64'd0);
    check("mrst_opcode", 64'(opcode), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_req("mrst_restart", ok);
    check("mrst_restart_addr", bus.imem_addr, RESET_PC);
    repeat (16) @(negedge clk);
    check("sb_drained_bound", 64'(exp_q.size() <= 1), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
